// File: rtl/calc_pkg.sv
// Shared sizing constants for the eight-way dispatch demux.
// Pure constants; no logic and no latency.
// No flow control here; consumers of these constants define backpressure.
package calc_pkg;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding register for one output channel (full flag plus data).
// Latency 1: a word loaded on one edge is presented on valid/data after that edge.
// Backpressure: holds its word while ready is low; a drain and a load in the same cycle chain with no bubble.
module demux_slot #(
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // A load wins over a drain so a consumer taking the word while a new one arrives sees no gap.
  // Data is zeroed whenever the slot empties so the output slice reads zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      data_q <= din;
    end else if (full_q && ready) begin
      full_q <= 1'b0;
      data_q <= '0;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/dispatch_demux8.sv
// Routes each accepted input word to one of NUM_CH single-entry output slots chosen by selector.
// Latency 1: an accepted word appears on its channel after the next rising edge; outputs are registered.
// Backpressure: in_ready drops when the selected slot is full and its consumer is not draining it, or during flush.
module dispatch_demux8 import calc_pkg::*; #(
  parameter int WIDTH  = calc_pkg::WIDTH,
  parameter int NUM_CH = calc_pkg::NUM_CH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [calc_pkg::SEL_W-1:0] selector,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [NUM_CH*WIDTH-1:0]    data_out,
  output logic [NUM_CH-1:0]          valid_out,
  input  logic [NUM_CH-1:0]          ready_in,
  output logic                       busy,
  output logic [15:0]                dispatch_cnt
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] load;
  logic              accept;
  logic [15:0]       cnt_q;

  // Selected slot can take a word if empty or if its current word leaves this same cycle.
  always_comb begin
    in_ready = !flush && (!full[selector] || ready_in[selector]);
    accept   = in_valid && in_ready;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_slot
      // One-hot decode of the selector gated by a successful handshake.
      assign load[i] = accept && (selector == calc_pkg::SEL_W'(i));

      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (load[i]),
        .din   (in_data),
        .ready (ready_in[i]),
        .full  (full[i]),
        .dout  (data_out[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Count accepted words; free-running wrap, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign valid_out    = full;
  assign busy         = |full;
  assign dispatch_cnt = cnt_q;

endmodule

// File: tb/tb_dispatch_demux8.sv
module tb_dispatch_demux8;

  localparam int W  = 32;
  localparam int NC = 8;

  logic              clk;
  logic              rst_n;
  logic [2:0]        selector;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [NC*W-1:0]   data_out;
  logic [NC-1:0]     valid_out;
  logic [NC-1:0]     ready_in;
  logic              busy;
  logic [15:0]       dispatch_cnt;

  int n_cmp;
  int n_bad;

  dispatch_demux8 #(.WIDTH(W), .NUM_CH(NC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .selector     (selector),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .busy         (busy),
    .dispatch_cnt (dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; selector = '0; in_data = '0; in_valid = 1'b0;
    flush = 1'b0; ready_in = '0;
    #3;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL reset_valid: got %h want 00", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dispatch_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", dispatch_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_accept();
    in_data = 32'h0000_00AA; selector = 3'b101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (valid_out !== 8'b0010_0000) begin n_bad++; $display("FAIL first_valid: got %b want 00100000", valid_out); end
    n_cmp++; if (data_out[5*W +: W] !== 32'h0000_00AA) begin n_bad++; $display("FAIL first_slice5: got %h want 000000aa", data_out[5*W +: W]); end
    n_cmp++; if (dispatch_cnt !== 16'd1) begin n_bad++; $display("FAIL first_cnt: got %0d want 1", dispatch_cnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy: got %b want 1", busy); end
    ready_in = 8'h20;
    tick();
    ready_in = 8'h00;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL first_drain_valid: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL first_drain_data: got %h want 0", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL first_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    selector = 3'd2; in_data = 32'h1111_2222; in_valid = 1'b1;
    tick();
    in_data = 32'h3333_4444;
    ready_in = 8'h00;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (data_out[2*W +: W] !== 32'h1111_2222) begin n_bad++; $display("FAIL bp_hold_slice2: got %h want 11112222", data_out[2*W +: W]); end
    n_cmp++; if (dispatch_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_cnt_blocked: got %0d want 2", dispatch_cnt); end
    ready_in = 8'h04;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_high: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (valid_out !== 8'h04) begin n_bad++; $display("FAIL bp_no_bubble: got %b want 00000100", valid_out); end
    n_cmp++; if (data_out[2*W +: W] !== 32'h3333_4444) begin n_bad++; $display("FAIL bp_new_slice2: got %h want 33334444", data_out[2*W +: W]); end
    n_cmp++; if (dispatch_cnt !== 16'd3) begin n_bad++; $display("FAIL bp_cnt: got %0d want 3", dispatch_cnt); end
    tick();
    ready_in = 8'h00;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL bp_drained: got %b want 0", valid_out); end
  endtask

  task automatic fill_all();
    for (int i = 0; i < NC; i++) begin
      selector = 3'(i);
      in_data  = 32'h11 * (i + 1);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    ready_in = 8'h00;
    fill_all();
    n_cmp++; if (valid_out !== 8'hFF) begin n_bad++; $display("FAIL fill_valid: got %h want ff", valid_out); end
    for (int i = 0; i < NC; i++) begin
      logic [W-1:0] exp_w;
      exp_w = 32'h11 * (i + 1);
      n_cmp++;
      if (data_out[i*W +: W] !== exp_w) begin
        n_bad++; $display("FAIL fill_slice%0d: got %h want %h", i, data_out[i*W +: W], exp_w);
      end
    end
    n_cmp++; if (dispatch_cnt !== 16'd11) begin n_bad++; $display("FAIL fill_cnt: got %0d want 11", dispatch_cnt); end
    ready_in = 8'hFF;
    tick();
    ready_in = 8'h00;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL drain_all_valid: got %h want 00", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL drain_all_data: got %h want 0", data_out); end
  endtask

  task automatic test_flush();
    fill_all();
    n_cmp++; if (valid_out !== 8'hFF) begin n_bad++; $display("FAIL flush_pre_valid: got %h want ff", valid_out); end
    flush = 1'b1; in_valid = 1'b1; selector = 3'd0; in_data = 32'hDEAD_BEEF; ready_in = 8'h00;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL flush_valid: got %h want 00", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL flush_data: got %h want 0", data_out); end
    n_cmp++; if (dispatch_cnt !== 16'd19) begin n_bad++; $display("FAIL flush_cnt: got %0d want 19", dispatch_cnt); end
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    selector = 3'd0; in_data = 32'h5A5A_5A5A; ready_in = 8'h01; in_valid = 1'b1;
    repeat (65535) tick();
    in_valid = 1'b0;
    n_cmp++; if (dispatch_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pre: got %h want ffff", dispatch_cnt); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (dispatch_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_post: got %h want 0000", dispatch_cnt); end
    tick();
    ready_in = 8'h00;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL wrap_drained: got %h want 00", valid_out); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      selector = 3'(i); in_data = 32'hC0DE_0000 + i; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (valid_out !== 8'h07) begin n_bad++; $display("FAIL areset_pre: got %h want 07", valid_out); end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 8'h00) begin n_bad++; $display("FAIL areset_valid: got %h want 00", valid_out); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL areset_data: got %h want 0", data_out); end
    n_cmp++; if (dispatch_cnt !== 16'h0) begin n_bad++; $display("FAIL areset_cnt: got %h want 0000", dispatch_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    selector = 3'd6; in_data = 32'h0BAD_F00D; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (valid_out !== 8'h40) begin n_bad++; $display("FAIL after_reset_valid: got %h want 40", valid_out); end
    n_cmp++; if (data_out[6*W +: W] !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL after_reset_slice6: got %h want 0badf00d", data_out[6*W +: W]); end
    n_cmp++; if (dispatch_cnt !== 16'd1) begin n_bad++; $display("FAIL after_reset_cnt: got %0d want 1", dispatch_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_first_accept();
    test_backpressure();
    test_fill_drain();
    test_flush();
    test_counter_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
